afe_ro_sram_buf_ctrl: RTL and testbench

//  Circular-buffer controller for the single-port AFE readout SRAM buffer (afe_ro_sram_buffer).

---
 rtl/afe_ro_buf_pkg.sv | 13 +
 rtl/afe_ro_buf_ptr.sv | 67 ++++++
 rtl/afe_ro_sram_buf_ctrl.sv | 130 +++++++++++++
 tb/tb_afe_ro_sram_buf_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/afe_ro_buf_pkg.sv
// Shared types and default sizes for the AFE readout SRAM buffer controller.
package afe_ro_buf_pkg;

  localparam int unsigned DEF_AFE_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH     = 10;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_RUN      = 2'd1,
    ST_BIST     = 2'd2
  } buf_state_e;

endpackage

// File: rtl/afe_ro_buf_ptr.sv
// Circular-buffer bookkeeping: write/read pointers, fill level, full/empty, clear.
module afe_ro_buf_ptr #(
  parameter int unsigned ADDR_WIDTH = afe_ro_buf_pkg::DEF_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  output logic [ADDR_WIDTH-1:0] wr_ptr_o,
  output logic [ADDR_WIDTH-1:0] rd_ptr_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic [ADDR_WIDTH:0]   level_d_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned LVL_W = ADDR_WIDTH + 1;
  localparam logic [LVL_W-1:0] DEPTH = LVL_W'(1) << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  full_q, empty_q;

  // Pointers wrap naturally at DEPTH; push and pop are mutually exclusive upstream.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else if (push_i) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      level_d  = level_q + LVL_W'(1);
    end else if (pop_i) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      level_d  = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= (level_d == DEPTH);
      empty_q  <= (level_d == '0);
    end
  end

  assign wr_ptr_o  = wr_ptr_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign level_o   = level_q;
  assign level_d_o = level_d;
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/afe_ro_sram_buf_ctrl.sv
// Single-port SRAM circular-buffer controller: AFE write stream (priority) plus
// req/gnt/rvalid readout, fill level, sticky overflow, watermark IRQ, BIST lockout.
module afe_ro_sram_buf_ctrl
  import afe_ro_buf_pkg::*;
#(
  parameter int unsigned AFE_DATA_WIDTH = DEF_AFE_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic                      clr_i,
  input  logic                      bist_en_i,
  input  logic [ADDR_WIDTH:0]       watermark_i,
  input  logic                      afe_valid_i,
  input  logic [AFE_DATA_WIDTH-1:0] afe_data_i,
  input  logic                      rd_req_i,
  output logic                      rd_gnt_o,
  output logic                      rd_rvalid_o,
  output logic [AFE_DATA_WIDTH-1:0] rd_rdata_o,
  output logic [ADDR_WIDTH:0]       level_o,
  output logic                      empty_o,
  output logic                      full_o,
  output logic                      overflow_o,
  output logic                      wm_irq_o,
  output logic                      sram_cen_o,
  output logic                      sram_wen_o,
  output logic [ADDR_WIDTH-1:0]     sram_addr_o,
  output logic [AFE_DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [AFE_DATA_WIDTH-1:0] sram_rdata_i
);

  buf_state_e state_q, state_d;

  logic                  run_c, push_c, pop_c, drop_c, flush_c;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  full, empty;
  logic                  wm_hit_now, wm_hit_next;
  logic                  rvalid_q, overflow_q, wm_irq_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_DISABLED;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bist_en_i) begin
      state_d = ST_BIST;
    end else begin
      case (state_q)
        ST_DISABLED: if (en_i) state_d = ST_RUN;
        ST_RUN:      if (!en_i) state_d = ST_DISABLED;
        ST_BIST:     state_d = ST_DISABLED;
        default:     state_d = ST_DISABLED;
      endcase
    end
  end

  // BIST blocks new accesses in the same cycle it asserts; clr beats everything.
  always_comb begin
    run_c   = (state_q == ST_RUN) && !bist_en_i;
    flush_c = clr_i || ((state_q == ST_BIST) && !bist_en_i);
    push_c  = run_c && afe_valid_i && !clr_i && !full;
    drop_c  = run_c && afe_valid_i && !clr_i && full;
    pop_c   = run_c && rd_req_i && !afe_valid_i && !clr_i && !empty;
  end

  always_comb begin
    sram_cen_o   = 1'b1;
    sram_wen_o   = 1'b1;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    if (push_c) begin
      sram_cen_o   = 1'b0;
      sram_wen_o   = 1'b0;
      sram_addr_o  = wr_ptr;
      sram_wdata_o = afe_data_i;
    end else if (pop_c) begin
      sram_cen_o  = 1'b0;
      sram_addr_o = rd_ptr;
    end
  end

  afe_ro_buf_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ptr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (flush_c),
    .push_i    (push_c),
    .pop_i     (pop_c),
    .wr_ptr_o  (wr_ptr),
    .rd_ptr_o  (rd_ptr),
    .level_o   (level_q),
    .level_d_o (level_d),
    .full_o    (full),
    .empty_o   (empty)
  );

  // Rising edge of (level >= watermark) aligned with the level_o update; zero disables.
  always_comb begin
    wm_hit_now  = (watermark_i != '0) && (level_q >= watermark_i);
    wm_hit_next = (watermark_i != '0) && (level_d >= watermark_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q   <= 1'b0;
      overflow_q <= 1'b0;
      wm_irq_q   <= 1'b0;
    end else begin
      rvalid_q <= pop_c;
      wm_irq_q <= wm_hit_next && !wm_hit_now;
      if (flush_c)     overflow_q <= 1'b0;
      else if (drop_c) overflow_q <= 1'b1;
    end
  end

  assign rd_gnt_o    = pop_c;
  assign rd_rvalid_o = rvalid_q;
  assign rd_rdata_o  = sram_rdata_i;
  assign level_o     = level_q;
  assign empty_o     = empty;
  assign full_o      = full;
  assign overflow_o  = overflow_q;
  assign wm_irq_o    = wm_irq_q;

endmodule

// File: tb/tb_afe_ro_sram_buf_ctrl.sv
// Randomized bench for afe_ro_sram_buf_ctrl (DEPTH=8) against a queue-based buffer model.
module tb_afe_ro_sram_buf_ctrl;

  localparam int AW    = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int M_DIS = 0, M_RUN = 1, M_BIST = 2;

  logic          clk = 1'b0;
  logic          rst_ni, en_i, clr_i, bist_en_i;
  logic [AW:0]   watermark_i;
  logic          afe_valid_i;
  logic [DW-1:0] afe_data_i;
  logic          rd_req_i, rd_gnt_o, rd_rvalid_o;
  logic [DW-1:0] rd_rdata_o;
  logic [AW:0]   level_o;
  logic          empty_o, full_o, overflow_o, wm_irq_o;
  logic          sram_cen_o, sram_wen_o;
  logic [AW-1:0] sram_addr_o;
  logic [DW-1:0] sram_wdata_o, sram_rdata;
  logic [DW-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  afe_ro_sram_buf_ctrl #(.AFE_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .clr_i(clr_i), .bist_en_i(bist_en_i),
    .watermark_i(watermark_i), .afe_valid_i(afe_valid_i), .afe_data_i(afe_data_i),
    .rd_req_i(rd_req_i), .rd_gnt_o(rd_gnt_o), .rd_rvalid_o(rd_rvalid_o),
    .rd_rdata_o(rd_rdata_o), .level_o(level_o), .empty_o(empty_o), .full_o(full_o),
    .overflow_o(overflow_o), .wm_irq_o(wm_irq_o), .sram_cen_o(sram_cen_o),
    .sram_wen_o(sram_wen_o), .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
    .sram_rdata_i(sram_rdata)
  );

  // Single-port SRAM with 1-cycle read latency
  always @(posedge clk) begin
    if (!sram_cen_o) begin
      if (!sram_wen_o) mem[sram_addr_o] <= sram_wdata_o;
      else             sram_rdata <= mem[sram_addr_o];
    end
  end

  int checks = 0, failures = 0;
  int mode;
  logic [DW-1:0] q[$];
  logic [DW-1:0] got_q[$];
  int wr_i, rd_i;
  bit ovf, prev_hit;
  int irq_cnt, cen_low_cnt, gnt_cnt;

  task automatic model_reset();
    mode = M_DIS; q.delete(); wr_i = 0; rd_i = 0; ovf = 0; prev_hit = 0;
  endtask

  // One clock: drive inputs, check access decisions, advance model, check registered outputs.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit req, input bit clr);
    bit run, push, pop, drop, flush, hit;
    logic [DW-1:0] exp_rd;
    exp_rd = '0;
    @(negedge clk);
    afe_valid_i = v; afe_data_i = d; rd_req_i = req; clr_i = clr;
    #1;
    run   = (mode == M_RUN) && !bist_en_i;
    push  = run && v && !clr && (q.size() < DEPTH);
    drop  = run && v && !clr && (q.size() == DEPTH);
    pop   = run && req && !v && !clr && (q.size() != 0);
    flush = clr || ((mode == M_BIST) && !bist_en_i);
    checks++;
    if (rd_gnt_o !== pop) begin
      failures++; $display("FAIL gnt t=%0t got=%b exp=%b", $time, rd_gnt_o, pop);
    end
    checks++;
    if (sram_cen_o !== !(push || pop)) begin
      failures++; $display("FAIL cen t=%0t got=%b exp=%b", $time, sram_cen_o, !(push || pop));
    end
    if (!sram_cen_o) cen_low_cnt++;
    if (rd_gnt_o) gnt_cnt++;
    if (push) begin
      checks++;
      if ({sram_wen_o, sram_addr_o, sram_wdata_o} !== {1'b0, AW'(wr_i), d}) begin
        failures++;
        $display("FAIL sram_write t=%0t got wen=%b addr=%0d data=%h exp wen=0 addr=%0d data=%h",
                 $time, sram_wen_o, sram_addr_o, sram_wdata_o, wr_i, d);
      end
    end
    if (pop) begin
      checks++;
      if ({sram_wen_o, sram_addr_o} !== {1'b1, AW'(rd_i)}) begin
        failures++;
        $display("FAIL sram_read t=%0t got wen=%b addr=%0d exp wen=1 addr=%0d",
                 $time, sram_wen_o, sram_addr_o, rd_i);
      end
    end
    @(posedge clk);
    if (flush) begin
      q.delete(); wr_i = 0; rd_i = 0; ovf = 0;
    end else begin
      if (push) begin q.push_back(d); wr_i = (wr_i + 1) % DEPTH; end
      if (drop) ovf = 1;
      if (pop) begin exp_rd = q.pop_front(); rd_i = (rd_i + 1) % DEPTH; end
    end
    if (bist_en_i)                          mode = M_BIST;
    else if (mode == M_DIS && en_i)         mode = M_RUN;
    else if (mode == M_RUN && !en_i)        mode = M_DIS;
    else if (mode == M_BIST)                mode = M_DIS;
    hit = (watermark_i != 0) && (q.size() >= int'(watermark_i));
    #1;
    checks++;
    if (rd_rvalid_o !== pop) begin
      failures++; $display("FAIL rvalid t=%0t got=%b exp=%b", $time, rd_rvalid_o, pop);
    end
    if (pop) begin
      checks++;
      if (rd_rdata_o !== exp_rd) begin
        failures++; $display("FAIL rdata t=%0t got=%h exp=%h", $time, rd_rdata_o, exp_rd);
      end
      got_q.push_back(rd_rdata_o);
    end
    checks++;
    if ({level_o, empty_o, full_o, overflow_o} !==
        {(AW+1)'(q.size()), q.size() == 0, q.size() == DEPTH, ovf}) begin
      failures++;
      $display("FAIL status t=%0t got level=%0d e=%b f=%b ovf=%b exp level=%0d ovf=%b",
               $time, level_o, empty_o, full_o, overflow_o, q.size(), ovf);
    end
    checks++;
    if (wm_irq_o !== (hit && !prev_hit)) begin
      failures++; $display("FAIL wm_irq t=%0t got=%b exp=%b", $time, wm_irq_o, hit && !prev_hit);
    end
    if (wm_irq_o) irq_cnt++;
    prev_hit = hit;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0);
  endtask

  task automatic test_reset();
    rst_ni = 0; en_i = 0; clr_i = 0; bist_en_i = 0; watermark_i = '0;
    afe_valid_i = 0; afe_data_i = '0; rd_req_i = 0;
    model_reset();
    #23;
    checks++;
    if ({level_o, empty_o, full_o, overflow_o, wm_irq_o, rd_gnt_o, rd_rvalid_o} !== {4'd0, 6'b100000}) begin
      failures++;
      $display("FAIL reset_flags got level=%0d e=%b f=%b ovf=%b irq=%b gnt=%b rv=%b exp 0,1,0,0,0,0,0",
               level_o, empty_o, full_o, overflow_o, wm_irq_o, rd_gnt_o, rd_rvalid_o);
    end
    checks++;
    if ({sram_cen_o, sram_wen_o, sram_addr_o, sram_wdata_o} !== {2'b11, {AW{1'b0}}, {DW{1'b0}}}) begin
      failures++;
      $display("FAIL reset_sram got cen=%b wen=%b addr=%0d wdata=%h exp 1,1,0,0",
               sram_cen_o, sram_wen_o, sram_addr_o, sram_wdata_o);
    end
    @(negedge clk); rst_ni = 1;
  endtask

  task automatic test_basic();
    logic [DW-1:0] a, b, c;
    a = $urandom; b = $urandom; c = $urandom;
    en_i = 1; idle(1);
    got_q.delete();
    step(1, a, 0, 0); step(1, b, 0, 0); step(1, c, 0, 0);
    checks++;
    if (level_o !== 4'd3) begin failures++; $display("FAIL basic_level3 got=%0d exp=3", level_o); end
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
    checks++;
    if (got_q.size() != 3 || got_q[0] !== a || got_q[1] !== b || got_q[2] !== c) begin
      failures++; $display("FAIL basic_order got %0d items exp %h %h %h", got_q.size(), a, b, c);
    end
    checks++;
    if (empty_o !== 1'b1 || level_o !== 4'd0) begin
      failures++; $display("FAIL basic_empty got e=%b level=%0d exp e=1 level=0", empty_o, level_o);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] data [9];
    got_q.delete();
    for (int i = 0; i < 9; i++) begin data[i] = $urandom; step(1, data[i], 0, 0); end
    checks++;
    if (full_o !== 1'b1 || overflow_o !== 1'b1) begin
      failures++; $display("FAIL ovf_flags got f=%b ovf=%b exp 1,1", full_o, overflow_o);
    end
    for (int i = 0; i < 9; i++) step(0, '0, 1, 0);
    checks++;
    if (got_q.size() != 8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== data[i]) begin
        failures++; $display("FAIL ovf_data[%0d] got=%h exp=%h", i, got_q[i], data[i]);
      end
    end
    step(0, '0, 0, 1);
    checks++;
    if (overflow_o !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow_o); end
  endtask

  task automatic test_arbitration();
    gnt_cnt = 0;
    for (int i = 0; i < 16; i++) step((i % 2) == 0, $urandom, 1, 0);
    checks++;
    if (gnt_cnt != 8) begin failures++; $display("FAIL arb_gnts got=%0d exp=8", gnt_cnt); end
    idle(1);
  endtask

  task automatic test_wrap();
    logic [DW-1:0] exp_q[$];
    step(0, '0, 0, 1);
    got_q.delete();
    for (int i = 0; i < 8; i++) begin exp_q.push_back($urandom); step(1, exp_q[i], 0, 0); end
    for (int i = 0; i < 5; i++) step(0, '0, 1, 0);
    for (int i = 0; i < 5; i++) begin exp_q.push_back($urandom); step(1, exp_q[8+i], 0, 0); end
    checks++;
    if (full_o !== 1'b1) begin failures++; $display("FAIL wrap_full got=%b exp=1", full_o); end
    for (int i = 0; i < 8; i++) step(0, '0, 1, 0);
    checks++;
    if (got_q != exp_q) begin failures++; $display("FAIL wrap_order got %0d items exp 13 in order", got_q.size()); end
  endtask

  task automatic test_watermark();
    step(0, '0, 0, 1);
    watermark_i = 4'd4; irq_cnt = 0;
    for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0);
    checks++;
    if (irq_cnt != 0) begin failures++; $display("FAIL wm_early got=%0d exp=0", irq_cnt); end
    step(1, $urandom, 0, 0);
    checks++;
    if (wm_irq_o !== 1'b1) begin failures++; $display("FAIL wm_pulse got=%b exp=1", wm_irq_o); end
    idle(4);
    checks++;
    if (irq_cnt != 1) begin failures++; $display("FAIL wm_once got=%0d exp=1", irq_cnt); end
    step(0, '0, 0, 1);
    watermark_i = '0;
  endtask

  task automatic test_bist();
    for (int i = 0; i < 5; i++) step(1, $urandom, 0, 0);
    step(0, '0, 1, 0);
    bist_en_i = 1; cen_low_cnt = 0;
    for (int i = 0; i < 10; i++) step(1, $urandom, 1, 0);
    checks++;
    if (cen_low_cnt != 0) begin failures++; $display("FAIL bist_cen got=%0d exp=0", cen_low_cnt); end
    bist_en_i = 0;
    idle(1);
    checks++;
    if (level_o !== 4'd0 || empty_o !== 1'b1 || mode != M_DIS) begin
      failures++; $display("FAIL bist_exit got level=%0d e=%b exp level=0 e=1", level_o, empty_o);
    end
    idle(1);
  endtask

  task automatic test_disable();
    for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0);
    en_i = 0; idle(1);
    cen_low_cnt = 0;
    for (int i = 0; i < 10; i++) step(1, $urandom, 1, 0);
    checks++;
    if (cen_low_cnt != 0 || level_o !== 4'd3 || overflow_o !== 1'b0) begin
      failures++; $display("FAIL disable_hold got cen_low=%0d level=%0d ovf=%b exp 0,3,0", cen_low_cnt, level_o, overflow_o);
    end
    en_i = 1; idle(1);
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
    step(1, $urandom, 0, 0); step(0, '0, 1, 0); step(0, '0, 0, 1);
  endtask

  task automatic test_random();
    step(0, '0, 0, 1);
    watermark_i = 4'd5;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 3) en_i = ~en_i;
      step($urandom_range(0, 99) < 45, $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 2);
    end
    en_i = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_arbitration();
    test_wrap();
    test_watermark();
    test_bist();
    test_disable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
